btn_conditioner: RTL



---
 rtl/btn_pkg.sv | 24 ++
 rtl/btn_debounce_ch.sv | 119 +++++++++++
 rtl/btn_conditioner.sv | 98 +++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioner: channel indices, the
// per-channel debounce state encoding and the default debounce length.
// No ports.
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int LEFT_BTN  = 0;
    localparam int RIGHT_BTN = 1;
    localparam int JUMP_BTN  = 2;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    // Bit 1 of the encoding is the debounced level.
    typedef enum logic [1:0] {
        IDLE_LO   = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b11,
        PEND_LO   = 2'b10
    } db_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One push-button channel: two-flop synchroniser, counter-based debounce FSM,
// registered one-cycle press/release pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE_LO   | level 0, input agrees with level
//   PEND_HI   | level 0, input high, counting stable-high cycles
//   STABLE_HI | level 1, input agrees with level
//   PEND_LO   | level 1, input low, counting stable-low cycles
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-high reset
//   btn_raw      in   asynchronous raw button level
//   btn_level    out  debounced level
//   btn_press    out  one-cycle pulse, registered, on accepted 0->1
//   btn_release  out  one-cycle pulse, registered, on accepted 1->0
//   press_evt    out  combinational: press accepted at the coming edge
//   release_evt  out  combinational: release accepted at the coming edge
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DB_CNT_WIDTH    = 20
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic press_evt,
    output logic release_evt
);

    // The counter holds the number of agreeing samples seen so far; the change
    // is accepted on the edge that would bring it to DEBOUNCE_CYCLES.
    localparam logic [DB_CNT_WIDTH-1:0] DB_LAST = DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                    s1;
    logic                    s2;
    db_state_e               state;
    db_state_e               state_nxt;
    logic [DB_CNT_WIDTH-1:0] cnt;
    logic [DB_CNT_WIDTH-1:0] cnt_nxt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= IDLE_LO;
            cnt         <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_press   <= press_evt;
            btn_release <= release_evt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        case (state)
            IDLE_LO: begin
                if (s2) begin
                    state_nxt = PEND_HI;
                    cnt_nxt   = DB_CNT_WIDTH'(1);
                end
            end
            PEND_HI: begin
                if (!s2) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt >= DB_LAST) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt + DB_CNT_WIDTH'(1);
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    state_nxt = PEND_LO;
                    cnt_nxt   = DB_CNT_WIDTH'(1);
                end
            end
            PEND_LO: begin
                if (s2) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt >= DB_LAST) begin
                    state_nxt   = IDLE_LO;
                    cnt_nxt     = '0;
                    release_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt + DB_CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign btn_level = state[1];

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Debounces the left/right/jump buttons and measures how long the selected
// button (jump) is held, as a saturating charge count.
//
// Ports:
//   sys_clk      in   system clock, 100 MHz
//   sys_rst      in   synchronous active-high reset
//   btn_raw      in   [BTN_NUM]    raw asynchronous button levels
//   btn_level    out  [BTN_NUM]    debounced levels
//   btn_press    out  [BTN_NUM]    one-cycle pulse on accepted press
//   btn_release  out  [BTN_NUM]    one-cycle pulse on accepted release
//   hold_cnt     out  [HOLD_WIDTH] live hold count of HOLD_BTN
//   hold_last    out  [HOLD_WIDTH] hold count captured at last release
//   hold_done    out  one-cycle pulse when hold_last updates
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int BTN_NUM         = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DB_CNT_WIDTH    = 20,
    parameter int HOLD_BTN        = JUMP_BTN,
    parameter int HOLD_DIV        = 2,
    parameter int HOLD_WIDTH      = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [BTN_NUM-1:0]    btn_raw,
    output logic [BTN_NUM-1:0]    btn_level,
    output logic [BTN_NUM-1:0]    btn_press,
    output logic [BTN_NUM-1:0]    btn_release,
    output logic [HOLD_WIDTH-1:0] hold_cnt,
    output logic [HOLD_WIDTH-1:0] hold_last,
    output logic                  hold_done
);

    localparam int                PRESC_W    = (HOLD_DIV > 1) ? $clog2(HOLD_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(HOLD_DIV - 1);

    logic [BTN_NUM-1:0] press_evt;
    logic [BTN_NUM-1:0] release_evt;
    logic [PRESC_W-1:0] presc;
    logic               unused_evt;

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_CNT_WIDTH    (DB_CNT_WIDTH)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .press_evt   (press_evt[i]),
            .release_evt (release_evt[i])
        );
    end

    // Only the hold channel's early events are consumed.
    assign unused_evt = ^{press_evt, release_evt};

    // The hold logic acts on the same edge that registers press/release, so
    // hold_cnt is 0 in the press cycle and hold_done coincides with btn_release.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_cnt  <= '0;
            hold_last <= '0;
            hold_done <= 1'b0;
            presc     <= '0;
        end else begin
            hold_done <= 1'b0;
            if (press_evt[HOLD_BTN]) begin
                hold_cnt <= '0;
                presc    <= '0;
            end else if (release_evt[HOLD_BTN]) begin
                hold_last <= hold_cnt;
                hold_done <= 1'b1;
                hold_cnt  <= '0;
                presc     <= '0;
            end else if (btn_level[HOLD_BTN]) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (hold_cnt != {HOLD_WIDTH{1'b1}}) begin
                        hold_cnt <= hold_cnt + HOLD_WIDTH'(1);
                    end
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end else begin
                presc <= '0;
            end
        end
    end

endmodule
